// File: rtl/proj_to_affine.sv
// proj_to_affine: projective (X,Y,Z) to affine (X/Z, Y/Z) mod q using an external inverter
// and two bit-serial MSB-first modular multiplications. Define INV_TIMEOUT_EN for inverter timeout.
module proj_to_affine #(
    parameter int MODULU_LENGTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [MODULU_LENGTH-1:0] prime_q,
    input  logic [MODULU_LENGTH-1:0] X,
    input  logic [MODULU_LENGTH-1:0] Y,
    input  logic [MODULU_LENGTH-1:0] Z,
    output logic                     busy,
    output logic [MODULU_LENGTH-1:0] x_aff,
    output logic [MODULU_LENGTH-1:0] y_aff,
    output logic                     out_valid,
    output logic                     inf,
    output logic                     err,
    output logic                     inv_go,
    output logic [MODULU_LENGTH-1:0] inv_a,
    output logic [MODULU_LENGTH-1:0] inv_q,
    input  logic                     inv_valid,
    input  logic [MODULU_LENGTH-1:0] inv_R
);
    localparam int N  = MODULU_LENGTH;
    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {IDLE, INV_START, INV_WAIT, MUL_X, MUL_Y, DONE} state_t;

    state_t        r_state, w_next;
    logic [N-1:0]  r_x, r_y, r_z, r_q, r_zinv, r_acc, r_xres;
    logic [IW-1:0] r_idx;
    logic [N:0]    w_q1, w_dbl, w_dbl_r, w_add;
    logic [N-1:0]  w_add_r, w_t, w_zinv;
    logic          w_bit, w_last, w_tmo;

    // One multiply iteration: acc = 2*acc (+ zinv if multiplier bit set), each step reduced once
    assign w_q1    = {1'b0, r_q};
    assign w_dbl   = {r_acc, 1'b0};
    assign w_dbl_r = w_dbl >= w_q1 ? w_dbl - w_q1 : w_dbl;
    assign w_add   = w_dbl_r + {1'b0, r_zinv};
    assign w_add_r = N'(w_add >= w_q1 ? w_add - w_q1 : w_add);
    assign w_bit   = r_state == MUL_X ? r_x[r_idx] : r_y[r_idx];
    assign w_t     = w_bit ? w_add_r : w_dbl_r[N-1:0];
    assign w_last  = r_idx == '0;
    assign w_zinv  = inv_R >= r_q ? inv_R - r_q : inv_R;

    assign busy      = r_state != IDLE;
    assign out_valid = r_state == DONE;
    assign inv_go    = r_state == INV_START;
    assign inv_a     = r_z;
    assign inv_q     = r_q;

`ifdef INV_TIMEOUT_EN
    localparam int CW = $clog2(4 * N);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    assign w_tmo = r_cnt == CW'(4 * N - 1);
    assign err   = r_err;
    // DONE is only reached from INV_WAIT via timeout, so that path alone raises err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= r_state == INV_WAIT ? r_cnt + 1'b1 : '0;
            if (w_next == DONE) r_err <= r_state == INV_WAIT;
        end
    end
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = start ? (Z == '0 ? DONE : INV_START) : IDLE;
            INV_START: w_next = INV_WAIT;
            INV_WAIT:  w_next = inv_valid ? MUL_X : (w_tmo ? DONE : INV_WAIT);
            MUL_X:     w_next = w_last ? MUL_Y : MUL_X;
            MUL_Y:     w_next = w_last ? DONE : MUL_Y;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_q     <= '0;
            r_zinv  <= '0;
            r_acc   <= '0;
            r_xres  <= '0;
            r_idx   <= '0;
            x_aff   <= '0;
            y_aff   <= '0;
            inf     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_x <= X;
                r_y <= Y;
                r_z <= Z;
                r_q <= prime_q;
            end
            if (r_state == INV_WAIT) begin
                r_acc <= '0;
                r_idx <= IW'(N - 1);
                if (inv_valid) r_zinv <= w_zinv;
            end
            if (r_state == MUL_X || r_state == MUL_Y) begin
                r_acc <= w_last ? '0 : w_t;
                r_idx <= w_last ? IW'(N - 1) : r_idx - 1'b1;
            end
            if (r_state == MUL_X && w_last) r_xres <= w_t;
            // Results are loaded on entry to DONE so they are valid alongside out_valid
            if (w_next == DONE) begin
                inf   <= r_state == IDLE;
                x_aff <= r_state == MUL_Y ? r_xres : '0;
                y_aff <= r_state == MUL_Y ? w_t : '0;
            end
        end
    end
endmodule

// File: tb/tb_proj_to_affine.sv
// tb_proj_to_affine: directed checks of proj_to_affine with a behavioural inverter of
// programmable latency W (inv_valid arrives in INV_WAIT cycle index W).
module tb_proj_to_affine;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] prime_q = '0, X = '0, Y = '0, Z = '0;
    logic         busy, out_valid, inf, err, inv_go;
    logic [N-1:0] x_aff, y_aff, inv_a, inv_q;
    logic         inv_valid;
    logic [N-1:0] inv_R;

    int checks = 0, errors = 0;
    int stub_w = 0, cnt, ov_cnt = 0, go_cnt = 0;
    bit stub_on = 1'b1, pend;
    logic [N-1:0] go_a, go_q;
    int lat, ov0, go0;
    logic bsy_ov;

    proj_to_affine #(.MODULU_LENGTH(N)) dut (
        .clk(clk), .rst(rst), .start(start), .prime_q(prime_q),
        .X(X), .Y(Y), .Z(Z), .busy(busy), .x_aff(x_aff), .y_aff(y_aff),
        .out_valid(out_valid), .inf(inf), .err(err), .inv_go(inv_go),
        .inv_a(inv_a), .inv_q(inv_q), .inv_valid(inv_valid), .inv_R(inv_R)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] modinv(input logic [N-1:0] a, input logic [N-1:0] m);
        for (longint r = 1; r < longint'(m); r++)
            if ((longint'(a) * r) % longint'(m) == 1) return N'(r);
        return '0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_valid <= 1'b0;
            inv_R     <= '0;
            pend      <= 1'b0;
            cnt       <= 0;
        end else begin
            inv_valid <= 1'b0;
            if (inv_go && stub_on) begin
                if (stub_w == 0) begin
                    inv_valid <= 1'b1;
                    inv_R     <= modinv(inv_a, inv_q);
                end else begin
                    pend <= 1'b1;
                    cnt  <= 1;
                end
            end else if (pend) begin
                if (cnt == stub_w) begin
                    inv_valid <= 1'b1;
                    inv_R     <= modinv(inv_a, inv_q);
                    pend      <= 1'b0;
                end else cnt <= cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid) ov_cnt++;
        if (inv_go) begin
            go_cnt++;
            go_a = inv_a;
            go_q = inv_q;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start an operation; optionally re-pulse start (intr_at) or pulse rst (rst_at) in that cycle.
    task automatic do_op(input logic [N-1:0] q, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [N-1:0] z, input int w, input int intr_at, input int rst_at,
                         output int l, output logic b);
        l = -1;
        b = 1'b0;
        stub_w = w;
        @(negedge clk);
        prime_q = q; X = x; Y = y; Z = z; start = 1'b1;
        for (int n = 1; n <= 300 && l < 0; n++) begin
            @(negedge clk);
            if (out_valid) begin
                l = n;
                b = busy;
            end
            start = n == intr_at;
            if (n == intr_at) begin
                prime_q = 32'd97; X = 32'd1; Y = 32'd1; Z = 32'd1;
            end
            rst = n == rst_at;
        end
        start = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_go", inv_go, 0);
        check("rst_x", x_aff, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        go0 = go_cnt;
        do_op(97, 10, 3, 5, 3, -1, -1, lat, bsy_ov);
        check("t1_lat", lat, 3 + 3 + 2 * N);
        check("t1_x", x_aff, 2);
        check("t1_y", y_aff, 20);
        check("t1_inf", inf, 0);
        check("t1_err", err, 0);
        check("t1_inv_a", go_a, 5);
        check("t1_inv_q", go_q, 97);
        check("t1_go_cnt", go_cnt - go0, 1);
        check("t1_busy_ov", bsy_ov, 1);
        @(negedge clk);
        check("t1_busy_after", busy, 0);
        check("t1_valid_after", out_valid, 0);

        do_op(97, 96, 0, 1, 0, -1, -1, lat, bsy_ov);
        check("t2_lat", lat, 3 + 0 + 2 * N);
        check("t2_x", x_aff, 96);
        check("t2_y", y_aff, 0);

        go0 = go_cnt;
        do_op(97, 55, 44, 0, 0, -1, -1, lat, bsy_ov);
        check("t3_lat", lat, 1);
        check("t3_inf", inf, 1);
        check("t3_x", x_aff, 0);
        check("t3_y", y_aff, 0);
        check("t3_busy_ov", bsy_ov, 1);
        check("t3_no_go", go_cnt - go0, 0);
        @(negedge clk);
        check("t3_busy_after", busy, 0);

        go0 = go_cnt;
        ov0 = ov_cnt;
        do_op(97, 10, 3, 5, 1, 10, -1, lat, bsy_ov);
        check("t4_lat", lat, 3 + 1 + 2 * N);
        check("t4_x", x_aff, 2);
        check("t4_y", y_aff, 20);
        check("t4_inf", inf, 0);
        repeat (80) @(negedge clk);
        check("t4_one_valid", ov_cnt - ov0, 1);
        check("t4_one_go", go_cnt - go0, 1);

        ov0 = ov_cnt;
        do_op(97, 10, 3, 5, 2, -1, 50, lat, bsy_ov);
        check("t5_no_valid", lat, -1);
        check("t5_ov_cnt", ov_cnt - ov0, 0);
        check("t5_busy", busy, 0);
        check("t5_rst_x", x_aff, 0);
        do_op(97, 10, 3, 5, 2, -1, -1, lat, bsy_ov);
        check("t5_lat", lat, 3 + 2 + 2 * N);
        check("t5_x", x_aff, 2);
        check("t5_y", y_aff, 20);

`ifdef INV_TIMEOUT_EN
        stub_on = 1'b0;
        do_op(97, 10, 3, 5, 0, -1, -1, lat, bsy_ov);
        check("t6_lat", lat, 2 + 4 * N);
        check("t6_err", err, 1);
        check("t6_x", x_aff, 0);
        check("t6_y", y_aff, 0);
        check("t6_inf", inf, 0);
        @(negedge clk);
        check("t6_busy_after", busy, 0);
        stub_on = 1'b1;
        do_op(97, 10, 3, 5, 0, -1, -1, lat, bsy_ov);
        check("t6_err_clear", err, 0);
        check("t6_x_again", x_aff, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
